// File: rtl/ram_pkg.sv
// Shared constants and types for the ram bus initiator.
package ram_pkg;

  localparam int DEPTH = 8;
  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int LW    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD    = 2'd1,
    ST_WR    = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/ram_master_if.sv
// Command/write/response streams plus the raw ram pin bundle.
// master = the ram_master view, slave = the control path / ram side view.
interface ram_master_if #(
  parameter int AW = ram_pkg::AW,
  parameter int DW = ram_pkg::DW,
  parameter int LW = ram_pkg::LW
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_rw;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          err;
  logic          busy;
  logic          ram_clr;
  logic          ram_enab;
  logic          ram_rw;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport master (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_len, wr_valid, wr_data, ram_rdata,
    output cmd_ready, wr_ready, rsp_valid, rsp_data, err, busy,
           ram_clr, ram_enab, ram_rw, ram_addr, ram_wdata
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_addr, cmd_len, wr_valid, wr_data, ram_rdata,
    input  cmd_ready, wr_ready, rsp_valid, rsp_data, err, busy,
           ram_clr, ram_enab, ram_rw, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_rsp_pipe.sv
// Read response pipe: tracks reads in flight through the ram's one-cycle
// latency and captures data_out into the response register.
module ram_rsp_pipe
  import ram_pkg::*;
#(
  parameter int DW = ram_pkg::DW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          i_rd_issue,   // a read is on the ram bus this cycle
  input  logic [DW-1:0] i_ram_rdata,
  output logic          o_rsp_valid,
  output logic [DW-1:0] o_rsp_data,
  output logic          o_empty
);

  logic          r_v0;      // ram has sampled the read, data_out now valid
  logic          r_v1;      // data captured, presented as a response
  logic [DW-1:0] r_data;

  // Shift the read marker along with the ram latency; capture when data_out is valid.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_v0   <= 1'b0;
      r_v1   <= 1'b0;
      r_data <= '0;
    end else begin
      r_v0 <= i_rd_issue;
      r_v1 <= r_v0;
      if (r_v0) begin
        r_data <= i_ram_rdata;
      end
    end
  end

  assign o_rsp_valid = r_v1;
  assign o_rsp_data  = r_data;
  // A read still sitting on the bus counts as in flight.
  assign o_empty     = !i_rd_issue && !r_v0 && !r_v1;

endmodule

// File: rtl/ram_master.sv
// Bus initiator for the small synchronous ram: accepts single/burst
// read and write commands and sequences them onto the ram pins.
module ram_master
  import ram_pkg::*;
#(
  parameter int DEPTH = ram_pkg::DEPTH,
  parameter int AW    = ram_pkg::AW,
  parameter int DW    = ram_pkg::DW,
  parameter int LW    = ram_pkg::LW
) (
  input  logic         clk,
  input  logic         clr,
  ram_master_if.master bus
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        r_state, w_state_next;
  logic [AW-1:0] r_cur, w_cur_next;
  logic [LW-1:0] r_beats, w_beats_next;
  logic          r_enab, w_enab_next;
  logic          r_rw, w_rw_next;
  logic [AW-1:0] r_addr, w_addr_next;
  logic [DW-1:0] r_wdata, w_wdata_next;
  logic          r_err, w_err_next;
  logic          r_ram_clr;

  logic          w_cmd_ready;
  logic          w_cmd_accept;
  logic          w_cmd_illegal;
  logic          w_rd_issue;
  logic          w_pipe_empty;
  logic [AW-1:0] w_cur_inc;
  logic          w_last_beat;

  // Commands only enter from IDLE and only once the ram is out of clear.
  assign w_cmd_ready   = (r_state == ST_IDLE) && r_ram_clr;
  assign w_cmd_accept  = bus.cmd_valid && w_cmd_ready;
  assign w_cmd_illegal = (int'(bus.cmd_addr) >= DEPTH) || (bus.cmd_len == '0) ||
                         (int'(bus.cmd_len) > DEPTH);
  assign w_cur_inc     = (r_cur == LAST_ADDR) ? '0 : r_cur + AW'(1);
  assign w_last_beat   = (r_beats == LW'(1));
  assign w_rd_issue    = r_enab && (r_rw == RW_READ);

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.wr_ready  = (r_state == ST_WR);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.err       = r_err;
  assign bus.ram_clr   = r_ram_clr;
  assign bus.ram_enab  = r_enab;
  assign bus.ram_rw    = r_rw;
  assign bus.ram_addr  = r_addr;
  assign bus.ram_wdata = r_wdata;

  // Next-state, burst counters and next bus values; the bus idles unless a beat is issued.
  always_comb begin
    w_state_next = r_state;
    w_cur_next   = r_cur;
    w_beats_next = r_beats;
    w_enab_next  = 1'b0;
    w_rw_next    = RW_READ;
    w_addr_next  = '0;
    w_wdata_next = '0;
    w_err_next   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_cmd_accept) begin
          if (w_cmd_illegal) begin
            w_err_next = 1'b1;
          end else begin
            w_state_next = (bus.cmd_rw == RW_WRITE) ? ST_WR : ST_RD;
            w_cur_next   = bus.cmd_addr;
            w_beats_next = bus.cmd_len;
          end
        end
      end
      ST_RD: begin
        w_enab_next  = 1'b1;
        w_rw_next    = RW_READ;
        w_addr_next  = r_cur;
        w_cur_next   = w_cur_inc;
        w_beats_next = r_beats - LW'(1);
        if (w_last_beat) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_WR: begin
        if (bus.wr_valid) begin
          w_enab_next  = 1'b1;
          w_rw_next    = RW_WRITE;
          w_addr_next  = r_cur;
          w_wdata_next = bus.wr_data;
          w_cur_next   = w_cur_inc;
          w_beats_next = r_beats - LW'(1);
          if (w_last_beat) begin
            w_state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // After a write the bus holds no read, so this releases after one cycle
        // while the ram commits the final beat.
        if (w_pipe_empty) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // FSM state and burst counters; reset aborts any burst in progress.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ST_IDLE;
      r_cur   <= '0;
      r_beats <= '0;
    end else begin
      r_state <= w_state_next;
      r_cur   <= w_cur_next;
      r_beats <= w_beats_next;
    end
  end

  // Registered ram bus and error pulse.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_enab  <= 1'b0;
      r_rw    <= RW_READ;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_enab  <= w_enab_next;
      r_rw    <= w_rw_next;
      r_addr  <= w_addr_next;
      r_wdata <= w_wdata_next;
      r_err   <= w_err_next;
    end
  end

  // Active-low ram clear follows reset with one edge of delay.
  always_ff @(posedge clk) begin
    r_ram_clr <= ~clr;
  end

  ram_rsp_pipe #(
    .DW (DW)
  ) u_rsp_pipe (
    .clk         (clk),
    .clr         (clr),
    .i_rd_issue  (w_rd_issue),
    .i_ram_rdata (bus.ram_rdata),
    .o_rsp_valid (bus.rsp_valid),
    .o_rsp_data  (bus.rsp_data),
    .o_empty     (w_pipe_empty)
  );

endmodule

// File: tb/tb_ram_master.sv
// Bench for ram_master driving a behavioural 8-location synchronous ram.
module tb_ram_master;
  import ram_pkg::*;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  ram_master_if #(.AW(8), .DW(8), .LW(4)) bus ();

  ram_master dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // Synchronous ram: active-low clear, write or read when enabled.
  logic [7:0] ram_mem [8];
  always @(posedge clk) begin
    if (!bus.ram_clr) begin
      for (int i = 0; i < 8; i++) ram_mem[i] <= 8'h00;
      bus.ram_rdata <= 8'h00;
    end else if (bus.ram_enab) begin
      if (bus.ram_rw) ram_mem[bus.ram_addr[2:0]] <= bus.ram_wdata;
      else            bus.ram_rdata <= ram_mem[bus.ram_addr[2:0]];
    end
  end

  int wr_count = 0;
  always @(posedge clk) begin
    if (bus.ram_clr && bus.ram_enab && bus.ram_rw) wr_count <= wr_count + 1;
  end

  int checks   = 0;
  int failures = 0;
  logic [7:0] model [8];       // expected ram contents
  logic [7:0] beat_data [8];   // payload for the next write burst

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic rw, input logic [7:0] addr, input logic [3:0] len,
                        output bit ok);
    int n = 0;
    while (!bus.cmd_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      $display("FAIL cmd_ready_timeout got=%b want=1", bus.cmd_ready);
      failures++;
      ok = 1'b0;
      return;
    end
    bus.cmd_rw    = rw;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    ok = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      $display("FAIL %s_idle_timeout busy=%b want=0", name, bus.busy);
      failures++;
    end
  endtask

  task automatic run_write(input logic [7:0] addr, input int len, input int gap);
    bit ok;
    int a;
    $display("WR addr=%0d len=%0d gap=%0d", addr, len, gap);
    do_cmd(1'b1, addr, 4'(len), ok);
    if (!ok) return;
    for (int b = 0; b < len; b++) begin
      if (b > 0) begin
        for (int g = 0; g < gap; g++) begin
          bus.wr_valid = 1'b0;
          tick();
          checks++;
          if (bus.ram_enab !== 1'b0) begin
            $display("FAIL gap_enab got=%b want=0", bus.ram_enab);
            failures++;
          end
          checks++;
          if (bus.busy !== 1'b1) begin
            $display("FAIL gap_busy got=%b want=1", bus.busy);
            failures++;
          end
        end
      end
      a = (int'(addr) + b) % 8;
      bus.wr_valid = 1'b1;
      bus.wr_data  = beat_data[b];
      tick();
      bus.wr_valid = 1'b0;
      checks++;
      if ({bus.ram_enab, bus.ram_rw, bus.ram_addr, bus.ram_wdata} !==
          {1'b1, 1'b1, 8'(a), beat_data[b]}) begin
        $display("FAIL wr_bus beat=%0d got en=%b rw=%b a=%0d d=%h want en=1 rw=1 a=%0d d=%h",
                 b, bus.ram_enab, bus.ram_rw, bus.ram_addr, bus.ram_wdata, a, beat_data[b]);
        failures++;
      end
      model[a] = beat_data[b];
    end
    checks++;
    if (bus.busy !== 1'b1) begin
      $display("FAIL drain_busy got=%b want=1", bus.busy);
      failures++;
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      $display("FAIL wr_done_busy got=%b want=0", bus.busy);
      failures++;
    end
  endtask

  task automatic run_read(input logic [7:0] addr, input int len);
    bit ok;
    bit exp_v;
    logic [7:0] exp_d;
    $display("RD addr=%0d len=%0d", addr, len);
    do_cmd(1'b0, addr, 4'(len), ok);
    if (!ok) return;
    for (int k = 1; k <= len + 4; k++) begin
      tick();
      exp_v = (k >= 3) && (k < 3 + len);
      checks++;
      if (bus.rsp_valid !== exp_v) begin
        $display("FAIL rsp_valid cyc=%0d got=%b want=%b", k, bus.rsp_valid, exp_v);
        failures++;
      end
      if (exp_v) begin
        exp_d = model[(int'(addr) + k - 3) % 8];
        checks++;
        if (bus.rsp_data !== exp_d) begin
          $display("FAIL rsp_data beat=%0d got=%h want=%h", k - 3, bus.rsp_data, exp_d);
          failures++;
        end
      end
    end
    wait_idle("rd");
  endtask

  task automatic check_mem(input string name);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ram_mem[i] !== model[i]) begin
        $display("FAIL %s_mem%0d got=%h want=%h", name, i, ram_mem[i], model[i]);
        failures++;
      end
    end
  endtask

  task automatic test_reset;
    clr = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus.ram_clr, bus.ram_enab, bus.ram_rw, bus.ram_addr, bus.ram_wdata, bus.err,
         bus.rsp_valid, bus.busy, bus.cmd_ready, bus.wr_ready} !== '0) begin
      $display("FAIL reset_outputs clr=%b en=%b rw=%b a=%h d=%h err=%b rv=%b busy=%b rdy=%b wrdy=%b want all 0",
               bus.ram_clr, bus.ram_enab, bus.ram_rw, bus.ram_addr, bus.ram_wdata, bus.err,
               bus.rsp_valid, bus.busy, bus.cmd_ready, bus.wr_ready);
      failures++;
    end
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    check_mem("reset");
    clr = 1'b0;
    tick();
    checks++;
    if (bus.ram_clr !== 1'b1) begin
      $display("FAIL release_ram_clr got=%b want=1", bus.ram_clr);
      failures++;
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      $display("FAIL release_cmd_ready got=%b want=1", bus.cmd_ready);
      failures++;
    end
  endtask

  task automatic test_single;
    beat_data[0] = 8'hA5;
    run_write(8'd3, 1, 0);
    check_mem("single");
    run_read(8'd3, 1);
  endtask

  task automatic test_burst_wrap;
    beat_data[0] = 8'h11;
    beat_data[1] = 8'h22;
    beat_data[2] = 8'h33;
    beat_data[3] = 8'h44;
    run_write(8'd6, 4, 0);
    check_mem("wrap");
    run_read(8'd6, 4);
  endtask

  task automatic test_write_gaps;
    int wc0;
    for (int i = 0; i < 3; i++) beat_data[i] = 8'($urandom);
    wc0 = wr_count;
    run_write(8'd2, 3, 2);
    checks++;
    if (wr_count - wc0 !== 3) begin
      $display("FAIL gap_write_count got=%0d want=3", wr_count - wc0);
      failures++;
    end
    check_mem("gaps");
  endtask

  task automatic test_illegal;
    logic [7:0] addrs [3];
    logic [3:0] lens  [3];
    bit ok;
    addrs[0] = 8'd8; lens[0] = 4'd1;
    addrs[1] = 8'd0; lens[1] = 4'd0;
    addrs[2] = 8'd0; lens[2] = 4'd9;
    for (int t = 0; t < 3; t++) begin
      $display("ILLEGAL addr=%0d len=%0d", addrs[t], lens[t]);
      do_cmd(1'($urandom), addrs[t], lens[t], ok);
      if (!ok) continue;
      checks++;
      if ({bus.err, bus.ram_enab, bus.cmd_ready, bus.busy} !== 4'b1010) begin
        $display("FAIL illegal_pulse t=%0d got err=%b en=%b rdy=%b busy=%b want 1 0 1 0",
                 t, bus.err, bus.ram_enab, bus.cmd_ready, bus.busy);
        failures++;
      end
      tick();
      checks++;
      if ({bus.err, bus.ram_enab, bus.cmd_ready} !== 3'b001) begin
        $display("FAIL illegal_after t=%0d got err=%b en=%b rdy=%b want 0 0 1",
                 t, bus.err, bus.ram_enab, bus.cmd_ready);
        failures++;
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] addr;
    int len;
    for (int t = 0; t < 12; t++) begin
      addr = 8'($urandom_range(0, 7));
      len  = $urandom_range(1, 8);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 8; i++) beat_data[i] = 8'($urandom);
        run_write(addr, len, $urandom_range(0, 2));
      end else begin
        run_read(addr, len);
      end
    end
    check_mem("random");
  endtask

  task automatic test_reset_mid;
    bit ok;
    for (int i = 0; i < 8; i++) beat_data[i] = 8'($urandom_range(1, 255));
    run_write(8'd0, 8, 0);
    $display("RD addr=0 len=8 (reset after 2 beats)");
    do_cmd(1'b0, 8'd0, 4'd8, ok);
    if (!ok) return;
    repeat (2) tick();
    clr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
        $display("FAIL mid_reset_rsp cyc=%0d got=%b want=0", k, bus.rsp_valid);
        failures++;
      end
    end
    clr = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.ram_enab !== 1'b0) begin
        $display("FAIL post_reset_quiet cyc=%0d rv=%b en=%b want 0 0", k, bus.rsp_valid, bus.ram_enab);
        failures++;
      end
    end
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    check_mem("midreset");
    run_read(8'd2, 1);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_rw    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    test_reset();
    test_single();
    test_burst_wrap();
    test_write_gaps();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
